// File: rtl/sim_run_ctrl.sv
// Simulation run controller: holds the core in reset, runs it, and detects a halt loop or a cycle timeout.
// Optional build macro SIM_RUN_CTRL_RETIRE_CNT_EN builds the retired-instruction counter.
module sim_run_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              CW          = 32,
  parameter int              RST_CYCLES  = 2,
  parameter longint unsigned MAX_CYCLES  = 1000,
  parameter int              HALT_REPEAT = 4,
  parameter int              TEST_REG    = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            retire_valid,
  input  logic [XLEN-1:0] retire_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            core_rst_n,
  output logic [1:0]      state,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   cycle_count,
  output logic [CW-1:0]   retire_count,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_e;

  localparam logic [7:0]    HOLD_LAST = 8'(RST_CYCLES - 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(MAX_CYCLES - 1);
  localparam logic [3:0]    REP_HALT  = 4'(HALT_REPEAT);
  localparam logic [4:0]    RES_REG   = 5'(TEST_REG);

  state_e          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [3:0]      rep_q, rep_d;
  logic            pass_q, pass_d;
  logic            halt_hit;
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
  logic [CW-1:0]   ret_q, ret_d;
`endif

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cyc_d     = cyc_q;
    result_d  = result_q;
    last_pc_d = last_pc_q;
    rep_d     = rep_q;
    pass_d    = pass_q;
    halt_hit  = 1'b0;
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
    ret_d     = ret_q;
`endif
    case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else                     hold_d  = hold_q + 8'd1;
      end
      S_RUN: begin
        if (wb_en && (wb_rd == RES_REG) && (wb_rd != 5'd0)) result_d = wb_data;
        if (retire_valid) begin
          last_pc_d = retire_pc;
          rep_d     = (retire_pc == last_pc_q) ? rep_q + 4'd1 : 4'd1;
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
          if (ret_q != '1) ret_d = ret_q + CW'(1);
`endif
        end
        halt_hit = retire_valid && (rep_d == REP_HALT);
        // Halt takes priority over a timeout landing on the same cycle.
        if (halt_hit) begin
          state_d = S_HALTED;
          pass_d  = (result_d == '0);
        end else if (cyc_q == CYC_LAST) begin
          state_d = S_TIMEOUT;
          pass_d  = 1'b0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HOLD;
      hold_q    <= '0;
      cyc_q     <= '0;
      result_q  <= '0;
      last_pc_q <= '0;
      rep_q     <= '0;
      pass_q    <= 1'b0;
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
      ret_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cyc_q     <= cyc_d;
      result_q  <= result_d;
      last_pc_q <= last_pc_d;
      rep_q     <= rep_d;
      pass_q    <= pass_d;
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
      ret_q     <= ret_d;
`endif
    end
  end

  assign state       = state_q;
  assign done        = state_q[1];
  assign core_rst_n  = (state_q != S_HOLD);
  assign pass        = pass_q;
  assign cycle_count = cyc_q;
  assign result      = result_q;
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
  assign retire_count = ret_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: directed run scenarios with hand-computed snapshots and terminal outcomes.
module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        core_rst_n;
  logic [1:0]  state;
  logic        done;
  logic        pass;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;
  logic [31:0] result;

  sim_run_ctrl #(
    .XLEN(32), .CW(32), .RST_CYCLES(2), .MAX_CYCLES(20), .HALT_REPEAT(4), .TEST_REG(10)
  ) dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .core_rst_n(core_rst_n),
    .state(state), .done(done), .pass(pass), .cycle_count(cycle_count),
    .retire_count(retire_count), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          sel;
    logic [63:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    logic [1:0]  st;
    logic        ps;
    logic [31:0] res;
    string       name;
  } term_t;

  chk_t  sb_q[$];
  term_t term_q[$];
  chk_t  c_m;
  term_t t_m;
  int    n_assert = 0;
  int    n_fail = 0;
  int    cyc = 0;
  logic  done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] probe(int sel);
    case (sel)
      0:       probe = 64'(state);
      1:       probe = 64'(core_rst_n);
      2:       probe = 64'(done);
      3:       probe = 64'(pass);
      4:       probe = 64'(cycle_count);
      5:       probe = 64'(retire_count);
      default: probe = 64'(result);
    endcase
  endfunction

  function automatic longint rcx(longint n);
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Monitor: snapshot checks due this cycle, plus terminal outcome on each rising done.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      c_m = sb_q.pop_front();
      n_assert++;
      if (c_m.due != cyc)
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", c_m.name, c_m.due, cyc);
      else if (probe(c_m.sel) !== c_m.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", c_m.name, probe(c_m.sel), c_m.exp);
      end
      if (c_m.due != cyc) n_fail++;
    end
    if (done === 1'b1 && !done_prev) begin
      n_assert++;
      if (term_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got state=%0d pass=%0b result=0x%0h, expected no termination",
                 state, pass, result);
      end else begin
        t_m = term_q.pop_front();
        if (state !== t_m.st || pass !== t_m.ps || result !== t_m.res) begin
          n_fail++;
          $display("FAIL %s_term: got state=%0d pass=%0b result=0x%0h expected state=%0d pass=%0b result=0x%0h",
                   t_m.name, state, pass, result, t_m.st, t_m.ps, t_m.res);
        end
      end
    end
    done_prev = (done === 1'b1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    retire_valid = 1'b0;
    retire_pc    = '0;
    wb_en        = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
  endtask

  task automatic push(string name, int sel, longint val);
    chk_t c;
    c.due  = cyc;
    c.sel  = sel;
    c.exp  = 64'(val);
    c.name = name;
    sb_q.push_back(c);
  endtask

  task automatic snap(string tag, int st, int crn, int dn, int ps, longint cc, longint rc, longint res);
    push({tag, ".state"}, 0, st);
    push({tag, ".core_rst_n"}, 1, crn);
    push({tag, ".done"}, 2, dn);
    push({tag, ".pass"}, 3, ps);
    push({tag, ".cycle_count"}, 4, cc);
    push({tag, ".retire_count"}, 5, rc);
    push({tag, ".result"}, 6, res);
  endtask

  task automatic expect_term(string name, logic [1:0] st, logic ps, logic [31:0] res);
    term_t t;
    t.st = st; t.ps = ps; t.res = res; t.name = name;
    term_q.push_back(t);
  endtask

  // Reset for n edges, release, and walk through the two HOLD cycles into RUN.
  task automatic do_reset(string tag, int n);
    rst = 1'b1;
    idle();
    repeat (n) tick();
    snap({tag, "_rst"}, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    snap({tag, "_hold"}, 0, 0, 0, 0, 0, 0, 0);
    tick();
    snap({tag, "_run0"}, 1, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    // Reset release and pass halt
    do_reset("rel", 2);
    wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h0;
    tick();
    idle();
    expect_term("pass_halt", 2'd2, 1'b1, 32'h0);
    repeat (4) begin retire_valid = 1'b1; retire_pc = 32'h40; tick(); end
    idle();
    snap("pass_halt", 2, 1, 1, 1, 4, rcx(4), 0);
    retire_valid = 1'b1; retire_pc = 32'h44; wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h7;
    repeat (3) tick();
    idle();
    snap("pass_sticky", 2, 1, 1, 1, 4, rcx(4), 0);

    // Fail halt, then a late write must not change the frozen result
    do_reset("fh", 2);
    wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h5;
    tick();
    idle();
    expect_term("fail_halt", 2'd2, 1'b0, 32'h5);
    repeat (4) begin retire_valid = 1'b1; retire_pc = 32'h80; tick(); end
    idle();
    snap("fail_halt", 2, 1, 1, 0, 4, rcx(4), 5);
    wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h0;
    tick();
    idle();
    snap("fail_late", 2, 1, 1, 0, 4, rcx(4), 5);

    // Timeout with distinct PCs; writes to x0 and x3 must not reach result
    do_reset("tmo", 2);
    for (int i = 0; i < 19; i++) begin
      retire_valid = 1'b1;
      retire_pc    = 32'h100 + 32'(4 * i);
      wb_en        = (i == 3) || (i == 5);
      wb_rd        = (i == 5) ? 5'd3 : 5'd0;
      wb_data      = (i == 5) ? 32'h44 : 32'h33;
      tick();
    end
    idle();
    snap("tmo_last", 1, 1, 0, 0, 19, rcx(19), 0);
    expect_term("timeout", 2'd3, 1'b0, 32'h0);
    retire_valid = 1'b1; retire_pc = 32'h100 + 32'(4 * 19);
    tick();
    idle();
    snap("tmo", 3, 1, 1, 0, 19, rcx(20), 0);
    retire_valid = 1'b1; retire_pc = 32'h40;
    repeat (3) tick();
    idle();
    snap("tmo_sticky", 3, 1, 1, 0, 19, rcx(20), 0);

    // Collision: 4th repeat lands on the last budget cycle with a same-cycle x10=0 write
    do_reset("col", 2);
    for (int i = 0; i < 16; i++) begin
      retire_valid = 1'b1;
      retire_pc    = 32'h1000 + 32'(4 * i);
      wb_en        = (i == 0);
      wb_rd        = 5'd10;
      wb_data      = 32'h5;
      tick();
    end
    idle();
    snap("col_pre", 1, 1, 0, 0, 16, rcx(16), 5);
    expect_term("collision", 2'd2, 1'b1, 32'h0);
    for (int i = 16; i < 20; i++) begin
      retire_valid = 1'b1;
      retire_pc    = 32'h200;
      wb_en        = (i == 19);
      wb_rd        = 5'd10;
      wb_data      = 32'h0;
      tick();
    end
    idle();
    snap("col", 2, 1, 1, 1, 19, rcx(20), 0);

    // Mid-run reset at cycle_count=7, then the sequence restarts
    do_reset("mid", 2);
    for (int i = 0; i < 7; i++) begin
      retire_valid = 1'b1;
      retire_pc    = 32'h300 + 32'(4 * i);
      wb_en        = (i == 2);
      wb_rd        = 5'd10;
      wb_data      = 32'h9;
      tick();
    end
    idle();
    snap("mid_pre", 1, 1, 0, 0, 7, rcx(7), 9);
    do_reset("mid_again", 1);
    retire_valid = 1'b1; retire_pc = 32'h300;
    repeat (2) tick();
    idle();
    snap("mid_post", 1, 1, 0, 0, 2, rcx(2), 0);

    tick();
    tick();
    n_assert++;
    if (term_q.size() != 0) begin
      n_fail++;
      $display("FAIL term_drain: got %0d pending terminal outcomes expected 0", term_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_run_ctrl.md
SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 Parameter XLEN, default 32: width of the monitored PC and writeback data.
REQ-002 Parameter CW, default 32: width of the cycle and retire counters.
REQ-003 Parameter RST_CYCLES, default 2: number of cycles core_rst_n is held low after rst deasserts; range 1..255.
REQ-004 Parameter MAX_CYCLES, default 1000: RUN-cycle budget before timeout; range 1 to 2^CW-1.
REQ-005 Parameter HALT_REPEAT, default 4: number of consecutive retirements of the same PC that signals a halt; range 2..15.
REQ-006 Parameter TEST_REG, default 10: architectural register holding the test result; range 1..31.
REQ-007 clk  input  1: single clock; all logic on the rising edge.
REQ-008 rst  input  1: synchronous, active-high reset.
REQ-009 retire_valid  input  1: one instruction retires this cycle.
REQ-010 retire_pc  input  XLEN: PC of the retiring instruction.
REQ-011 wb_en  input  1: register-file write this cycle.
REQ-012 wb_rd  input  5: destination register.
REQ-013 wb_data  input  XLEN: write data.
REQ-014 core_rst_n  output  1: active-low reset driven to the pipeline core.
REQ-015 state  output  2: encoding HOLD=0, RUN=1, HALTED=2, TIMEOUT=3.
REQ-016 done  output  1: asserted in HALTED or TIMEOUT.
REQ-017 pass  output  1: result of the halt check; valid when done is high.
REQ-018 cycle_count  output  CW: number of RUN cycles elapsed.
REQ-019 retire_count  output  CW: number of retired instructions.
REQ-020 result  output  XLEN: last value written to TEST_REG.

Function
REQ-021 HOLD: core_rst_n=0; internal hold counter increments each cycle; after RST_CYCLES HOLD cycles, transition to RUN; core_rst_n=1 from the first RUN cycle.
REQ-022 RUN: cycle_count increments by 1 each cycle, starting from 0 on the first RUN cycle.
REQ-023 Halt detection: when retire_valid and retire_pc equals the last retired PC, the repeat counter increments; on any other retirement it loads 1; when it reaches HALT_REPEAT, transition to HALTED next cycle.
REQ-024 Timeout: a RUN cycle in which cycle_count equals MAX_CYCLES-1 with no halt transitions to TIMEOUT next cycle.
REQ-025 Halt and timeout detected in the same cycle: HALTED wins.
REQ-026 Result capture: when wb_en is high in RUN and wb_rd equals TEST_REG, result loads wb_data; writes with wb_rd=0 are ignored; a capture in the halting cycle is included in the pass evaluation.
REQ-027 pass is set to 1 on entry to HALTED iff result (including any same-cycle capture) is 0; in TIMEOUT pass is 0.
REQ-028 HALTED and TIMEOUT are sticky until rst; counters and result freeze; core_rst_n stays 1; retire/wb inputs are ignored.
REQ-029 Inputs are ignored in HOLD.
REQ-030 retire_count saturates at all-ones; cycle_count never wraps, because MAX_CYCLES is at most 2^CW-1.

Reset
REQ-031 On rst, at the next rising edge:
- state=HOLD, core_rst_n=0, done=0, pass=0.
- cycle_count=0, retire_count=0, result=0.
- Repeat counter, last-PC register and hold counter are cleared.
REQ-032 rst asserted mid-RUN or in a terminal state aborts immediately with the same reset values, and HOLD restarts for RST_CYCLES cycles after rst deasserts.

Configuration
REQ-033 Macro SIM_RUN_CTRL_RETIRE_CNT_EN:
- Defined: retire_count increments on each RUN cycle with retire_valid high.
- Undefined: retire_count is tied to 0 and the counter is not built.
- All other behaviour is identical in both builds.

Verification
REQ-034 Reset release: rst high for 2 cycles, then low with RST_CYCLES=2 -> core_rst_n=0 for exactly 2 cycles, then 1; state goes 0 then 1.
REQ-035 Pass halt: write 0 to x10, then retire PC 0x40 four times consecutively -> state=2, done=1, pass=1, result=0.
REQ-036 Fail halt: write 0x5 to x10, then retire the same PC 4 times -> done=1, pass=0, result=0x5; a later write of 0 to x10 leaves result=0x5.
REQ-037 Timeout: MAX_CYCLES=20 with no repeated PC -> state=3 once cycle_count=19, pass=0, cycle_count frozen at 19.
REQ-038 Collision: the 4th repeat retirement coincides with cycle_count=MAX_CYCLES-1 and x10=0 is written in the same cycle -> HALTED, pass=1.
REQ-039 Mid-run reset: assert rst at cycle_count=7 -> next cycle counters=0 and core_rst_n=0; the sequence restarts; with the macro undefined, retire_count=0 throughout.
